heap_sift_up: RTL and testbench

Sequential max-heap insert engine: accepts one key per handshake, appends it at index `count`, and bubbles it toward the root by comparing with parent `(idx-1)>>1` until parent ≥ key or root reached. It is the insert-side counterpart of the combinational sift-down (extract) path. It drives an external synchronous heap RAM and publishes the current heap size to the extract side.

---
 rtl/heap_pkg.sv | 23 ++
 rtl/heap_sift_up.sv | 126 ++++++++++++
 tb/tb_heap_sift_up.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/heap_pkg.sv
// heap_pkg: constants and types shared by the heap insert (sift-up) and
// extract (sift-down) engines.
//   HEAP_DATA_W : default key width (unsigned keys)
//   HEAP_ADDR_W : default heap index width; capacity is 2**HEAP_ADDR_W
//   state_t     : insert engine states
//   parent()    : index of the parent of a heap slot, (idx-1)>>1
package heap_pkg;

  localparam int HEAP_DATA_W = 32;
  localparam int HEAP_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CMP
  } state_t;

  // Only meaningful for idx > 0; callers never ask for the root's parent.
  function automatic logic [31:0] parent(input logic [31:0] idx);
    return (idx - 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/heap_sift_up.sv
// heap_sift_up: sequential max-heap insert engine.
// Accepts one key per handshake, places it at index `count`, and bubbles it
// toward the root, moving each smaller parent down one level, until the
// parent is >= key or the root is reached. The key is written exactly once,
// at its final slot. Drives an external synchronous RAM (1-cycle read).
//   clk, rst_n          : clock, asynchronous active-low reset
//   ins_valid/ins_ready : insert handshake; ins_data is the key
//   clear               : empty the heap (count <- 0), honoured only when idle
//   count, full         : current heap size, size == capacity
//   busy, done          : insert in progress, one-cycle completion pulse
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata: heap RAM port
module heap_sift_up
  import heap_pkg::*;
#(
  parameter int DATA_W = HEAP_DATA_W,
  parameter int ADDR_W = HEAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              clear,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] parent_idx;
  logic              at_root;
  logic              climb;
  logic              accept;
  logic              finish;

  assign parent_idx = ADDR_W'(parent(32'(idx)));
  assign at_root    = (idx == '0);
  // Strict compare: an equal parent stops the climb.
  assign climb      = (key > mem_rdata);

  assign full      = (count == CAPACITY);
  assign busy      = (state != IDLE);
  assign ins_ready = (state == IDLE) && !full && !clear;
  assign accept    = ins_valid && ins_ready;
  assign finish    = ((state == CHECK) && at_root) || ((state == CMP) && !climb);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = at_root ? IDLE : CMP;
      CMP:     state_nxt = climb ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port is a pure decode of state, so it reads all-zero while idle or in
  // reset. CHECK reads the parent (or writes the root); CMP always writes:
  // either the parent moves down into idx, or the key lands at idx.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      CHECK: begin
        if (at_root) begin
          mem_we    = 1'b1;
          mem_addr  = idx;
          mem_wdata = key;
        end else begin
          mem_addr  = parent_idx;
        end
      end
      CMP: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = climb ? mem_rdata : key;
      end
      default: ;
    endcase
  end

  // The heap RAM lives outside this block and is not reset; its contents are
  // meaningless after rst_n because count returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key   <= '0;
      idx   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (finish) count <= count + (ADDR_W+1)'(1);
      if (state == IDLE) begin
        // ins_ready is low while clear is high, so clear always wins.
        if (clear) begin
          count <= '0;
        end else if (accept) begin
          key <= ins_data;
          idx <= count[ADDR_W-1:0];
        end
      end
      if ((state == CMP) && climb) idx <= parent_idx;
    end
  end

endmodule

// File: tb/tb_heap_sift_up.sv
// tb_heap_sift_up: self-checking bench for heap_sift_up.
// A 16-entry instance covers timing, ordering, clear and reset; a 4-entry
// instance covers full/back-pressure. Each DUT drives a behavioural 1R/1W RAM
// with one-cycle read latency. A software heap model pushes the expected
// outcome of every insert to a scoreboard queue; the entry is popped and
// compared when the DUT pulses done.
module tb_heap_sift_up;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int AWS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- large instance ----------------
  logic          ins_valid = 1'b0;
  logic [DW-1:0] ins_data = '0;
  logic          clear = 1'b0;
  logic          ins_ready, full, busy, done, mem_we;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] ram [2**AW];

  heap_sift_up #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .clear(clear), .count(count), .full(full),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- small instance ----------------
  logic           s_valid = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic           s_clear = 1'b0;
  logic           s_ready, s_full, s_busy, s_done, s_we;
  logic [AWS:0]   s_count;
  logic [AWS-1:0] s_addr;
  logic [DW-1:0]  s_wdata, s_rdata;
  logic [DW-1:0]  s_ram [2**AWS];

  heap_sift_up #(.DATA_W(DW), .ADDR_W(AWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .ins_valid(s_valid), .ins_ready(s_ready),
    .ins_data(s_data), .clear(s_clear), .count(s_count), .full(s_full),
    .busy(s_busy), .done(s_done), .mem_addr(s_addr), .mem_we(s_we),
    .mem_wdata(s_wdata), .mem_rdata(s_rdata)
  );

  always @(posedge clk) begin
    if (s_we) s_ram[s_addr] <= s_wdata;
    s_rdata <= s_ram[s_addr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- model and scoreboard ----------------
  typedef struct {
    int lat;     // cycles from accept to done
    int cnt;     // count after done
    int writes;  // RAM writes during the insert
    int reads;   // RAM reads during the insert
    int waddr;   // slot of the final write
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [2**AW];
  int            msize = 0;
  int            last_lat = 0;

  task automatic model_insert(input logic [DW-1:0] k_in);
    exp_t e;
    int i = msize;
    int k = 0;
    while (i > 0 && k_in > model[(i-1)/2]) begin
      model[i] = model[(i-1)/2];
      i = (i-1)/2;
      k++;
    end
    model[i] = k_in;
    msize++;
    e.lat    = (i == 0) ? 2 + 2*k : 3 + 2*k;
    e.cnt    = msize;
    e.writes = k + 1;
    e.reads  = (i == 0) ? k : k + 1;
    e.waddr  = i;
    sb.push_back(e);
  endtask

  task automatic do_insert(input logic [DW-1:0] k_in);
    exp_t e;
    int n, wr, rd, lastw, lastc;
    model_insert(k_in);
    @(posedge clk) #1;
    ins_valid = 1'b1;
    ins_data  = k_in;
    @(negedge clk);
    check("ins_ready_before_accept", ins_ready, 1);
    @(posedge clk) #1;
    ins_valid = 1'b0;
    n = 1; wr = 0; rd = 0; lastw = -1; lastc = -1;
    @(negedge clk);
    while (!done && n < 40) begin
      if (busy) begin
        if (mem_we) begin wr++; lastw = int'(mem_addr); lastc = n; end
        else rd++;
      end
      @(negedge clk);
      n++;
    end
    last_lat = n;
    e = sb.pop_front();
    check("done_latency", n, e.lat);
    check("count_at_done", count, e.cnt);
    check("ram_writes", wr, e.writes);
    check("ram_reads", rd, e.reads);
    check("final_write_addr", lastw, e.waddr);
    check("final_write_cycle", lastc, e.lat - 1);
    if (msize < 2**AW) check("ready_in_done_cycle", ins_ready, 1);
    for (int j = 0; j < msize; j++) check($sformatf("ram[%0d]", j), ram[j], model[j]);
  endtask

  task automatic s_insert(input logic [DW-1:0] k_in);
    int n;
    @(posedge clk) #1;
    s_valid = 1'b1;
    s_data  = k_in;
    @(posedge clk) #1;
    s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("small_done_seen", s_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1;
    check("rst_ready", ins_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty heap, then 3, 8 (root climb), then an equal key that stops
    do_insert(32'd5);
    check("empty_insert_latency", last_lat, 2);
    do_insert(32'd3);
    do_insert(32'd8);
    check("root_climb_latency", last_lat, 4);
    check("heap_0", ram[0], 8);
    check("heap_1", ram[1], 3);
    check("heap_2", ram[2], 5);
    do_insert(32'd3);
    check("equal_stop_latency", last_lat, 3);
    check("equal_stop_slot", ram[3], 3);

    // Clear while idle
    @(posedge clk) #1;
    clear = 1'b1;
    @(negedge clk);
    check("ready_during_clear", ins_ready, 0);
    @(posedge clk) #1;
    clear = 1'b0;
    @(negedge clk);
    check("count_after_clear", count, 0);
    msize = 0;

    // Ascending 1..15: every key climbs to the root
    for (int v = 1; v <= 15; v++) do_insert(DW'(v));
    check("ascending_root", ram[0], 15);
    check("ascending_last_latency", last_lat, 8);

    // Reset in the middle of an insert (key 16 at idx 15 reaches CMP at T+2)
    @(posedge clk) #1;
    ins_valid = 1'b1;
    ins_data  = 32'd16;
    @(posedge clk) #1;
    ins_valid = 1'b0;
    @(posedge clk) #1;
    check("midop_busy", busy, 1);
    check("midop_mem_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_we", mem_we, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    msize = 0;
    @(negedge clk);
    check("ready_after_rst", ins_ready, 1);
    do_insert(32'd7);
    check("post_rst_root", ram[0], 7);
    do_insert(32'hFFFF_FFFF);
    do_insert(32'h8000_0000);

    // Small instance: fill, back-pressure, clear, clear-vs-insert
    for (int v = 1; v <= 4; v++) s_insert(DW'(v));
    check("small_count_full", s_count, 4);
    check("small_full", s_full, 1);
    check("small_root", s_ram[0], 4);
    @(posedge clk) #1;
    s_valid = 1'b1;
    s_data  = 32'd9;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("small_ready_when_full", s_ready, 0);
    end
    check("small_not_busy_when_full", s_busy, 0);
    @(posedge clk) #1;
    s_valid = 1'b0;
    check("small_count_held", s_count, 4);
    @(posedge clk) #1;
    s_clear = 1'b1;
    @(posedge clk) #1;
    s_clear = 1'b0;
    @(negedge clk);
    check("small_count_cleared", s_count, 0);
    check("small_full_cleared", s_full, 0);
    @(posedge clk) #1;
    s_clear = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'd6;
    @(negedge clk);
    check("small_ready_clear_and_valid", s_ready, 0);
    @(posedge clk) #1;
    s_clear = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("small_no_accept_on_clear", s_busy, 0);
    check("small_count_after_clear_valid", s_count, 0);
    s_insert(32'd6);
    check("small_count_after_insert", s_count, 1);
    check("small_root_after_insert", s_ram[0], 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
